// File: rtl/weight_sched_pkg.sv
// Shared types and default widths for the weight-load job scheduler.
package weight_sched_pkg;

  localparam int unsigned DEF_TILE_CNT_WIDTH = 8;
  localparam int unsigned DEF_TIMEOUT_WIDTH  = 16;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR_FIFO,
    S_CLR_WS,
    S_LOAD,
    S_ISSUE,
    S_COMPUTE,
    S_NEXT,
    S_FINISH,
    S_ERR
  } sched_state_t;

endpackage

// File: rtl/tile_idx_counter.sv
// Nested (filter outer, channel inner) tile index counter for the weight-load scheduler.
module tile_idx_counter
  import weight_sched_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_TILE_CNT_WIDTH
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             clear,
  input  logic             advance,
  input  logic [WIDTH-1:0] num_filters,
  input  logic [WIDTH-1:0] num_channels,
  output logic [WIDTH-1:0] filter_idx,
  output logic [WIDTH-1:0] channel_idx,
  output logic             last
);

  logic chan_wrap;

  assign chan_wrap = (channel_idx == num_channels - WIDTH'(1));
  assign last      = chan_wrap && (filter_idx == num_filters - WIDTH'(1));

  // The final tile holds its indices so they remain visible after the job ends.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      filter_idx  <= '0;
      channel_idx <= '0;
    end else if (clear) begin
      filter_idx  <= '0;
      channel_idx <= '0;
    end else if (advance && !last) begin
      if (chan_wrap) begin
        channel_idx <= '0;
        filter_idx  <= filter_idx + WIDTH'(1);
      end else begin
        channel_idx <= channel_idx + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/weight_load_sched.sv
// Job-level scheduler: clears the weight FIFO, then per tile clears/loads the
// weight store and hands it to the compute array until all tiles are done.
module weight_load_sched
  import weight_sched_pkg::*;
#(
  parameter int unsigned TILE_CNT_WIDTH = DEF_TILE_CNT_WIDTH,
  parameter int unsigned TIMEOUT_WIDTH  = DEF_TIMEOUT_WIDTH
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      START,
  input  logic [TILE_CNT_WIDTH-1:0] CFG_NUM_FILTERS,
  input  logic [TILE_CNT_WIDTH-1:0] CFG_NUM_CHANNELS,
  input  logic [TIMEOUT_WIDTH-1:0]  CFG_TIMEOUT,
  output logic                      BUSY,
  output logic                      DONE,
  output logic                      ERROR,
  output logic                      CLEAR_FIFO,
  output logic                      WS_CLEAR,
  output logic                      LOAD_WS,
  input  logic                      WS_FULL,
  output logic                      COMPUTE_VALID,
  input  logic                      COMPUTE_READY,
  input  logic                      COMPUTE_DONE,
  output logic [TILE_CNT_WIDTH-1:0] FILTER_IDX,
  output logic [TILE_CNT_WIDTH-1:0] CHANNEL_IDX
);

  sched_state_t state_q, state_d;

  logic [TILE_CNT_WIDTH-1:0] num_filters_q, num_channels_q;
  logic [TIMEOUT_WIDTH-1:0]  timeout_q, load_cnt;
  logic [TIMEOUT_WIDTH:0]    load_elapsed;
  logic                      error_q, start_acc, load_first, tile_last;

  assign start_acc  = (state_q == S_IDLE) && START;
  assign load_first = (load_cnt == '0);
  // Cycles spent in LOAD including the current one; the saturating counter never returns to 0.
  assign load_elapsed = {1'b0, load_cnt} + (TIMEOUT_WIDTH + 1)'(1);

  tile_idx_counter #(
    .WIDTH (TILE_CNT_WIDTH)
  ) u_tile_idx (
    .CLK          (CLK),
    .RESET        (RESET),
    .clear        (start_acc),
    .advance      (state_q == S_NEXT),
    .num_filters  (num_filters_q),
    .num_channels (num_channels_q),
    .filter_idx   (FILTER_IDX),
    .channel_idx  (CHANNEL_IDX),
    .last         (tile_last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (START) state_d = (CFG_NUM_FILTERS == '0 || CFG_NUM_CHANNELS == '0)
                                       ? S_FINISH : S_CLR_FIFO;
      S_CLR_FIFO: state_d = S_CLR_WS;
      S_CLR_WS:   state_d = S_LOAD;
      S_LOAD: begin
        if (!load_first && WS_FULL)
          state_d = S_ISSUE;
        else if (timeout_q != '0 && load_elapsed == {1'b0, timeout_q})
          state_d = S_ERR;
      end
      S_ISSUE:    if (COMPUTE_READY) state_d = S_COMPUTE;
      S_COMPUTE:  if (COMPUTE_DONE) state_d = S_NEXT;
      S_NEXT:     state_d = tile_last ? S_FINISH : S_CLR_WS;
      S_FINISH:   state_d = S_IDLE;
      S_ERR:      state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q        <= S_IDLE;
      num_filters_q  <= '0;
      num_channels_q <= '0;
      timeout_q      <= '0;
      load_cnt       <= '0;
      error_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        num_filters_q  <= CFG_NUM_FILTERS;
        num_channels_q <= CFG_NUM_CHANNELS;
        timeout_q      <= CFG_TIMEOUT;
        error_q        <= 1'b0;
      end else if (state_q == S_ERR) begin
        error_q <= 1'b1;
      end
      if (state_q == S_CLR_WS)
        load_cnt <= '0;
      else if (state_q == S_LOAD && load_cnt != '1)
        load_cnt <= load_cnt + TIMEOUT_WIDTH'(1);
    end
  end

  assign BUSY          = (state_q != S_IDLE);
  assign DONE          = (state_q == S_FINISH);
  assign ERROR         = error_q;
  assign CLEAR_FIFO    = (state_q == S_CLR_FIFO);
  assign WS_CLEAR      = (state_q == S_CLR_WS);
  assign LOAD_WS       = (state_q == S_LOAD);
  assign COMPUTE_VALID = (state_q == S_ISSUE);

endmodule

// File: tb/tb_weight_load_sched.sv
// Scoreboard bench for weight_load_sched: directed jobs with hand-computed tile order and timing.
module tb_weight_load_sched;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        START = 1'b0;
  logic [7:0]  CFG_NUM_FILTERS = '0;
  logic [7:0]  CFG_NUM_CHANNELS = '0;
  logic [15:0] CFG_TIMEOUT = '0;
  logic        WS_FULL = 1'b0;
  logic        COMPUTE_READY = 1'b0;
  logic        COMPUTE_DONE = 1'b0;
  logic        BUSY, DONE, ERROR, CLEAR_FIFO, WS_CLEAR, LOAD_WS, COMPUTE_VALID;
  logic [7:0]  FILTER_IDX, CHANNEL_IDX;

  always #5 CLK = ~CLK;

  weight_load_sched #(
    .TILE_CNT_WIDTH (8),
    .TIMEOUT_WIDTH  (16)
  ) dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .START            (START),
    .CFG_NUM_FILTERS  (CFG_NUM_FILTERS),
    .CFG_NUM_CHANNELS (CFG_NUM_CHANNELS),
    .CFG_TIMEOUT      (CFG_TIMEOUT),
    .BUSY             (BUSY),
    .DONE             (DONE),
    .ERROR            (ERROR),
    .CLEAR_FIFO       (CLEAR_FIFO),
    .WS_CLEAR         (WS_CLEAR),
    .LOAD_WS          (LOAD_WS),
    .WS_FULL          (WS_FULL),
    .COMPUTE_VALID    (COMPUTE_VALID),
    .COMPUTE_READY    (COMPUTE_READY),
    .COMPUTE_DONE     (COMPUTE_DONE),
    .FILTER_IDX       (FILTER_IDX),
    .CHANNEL_IDX      (CHANNEL_IDX)
  );

  localparam int EV_TILE = 0;
  localparam int EV_DONE = 1;
  localparam int EV_ERR  = 2;

  typedef struct {
    int kind;
    int f;
    int c;
  } ev_t;

  ev_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // responder settings
  int full_delay  = 5;
  int ready_delay = 0;
  int done_delay  = 4;
  bit spur_done   = 1'b0;
  int exp_vrun    = 0;

  // monitor statistics
  int n_clear_fifo = 0, n_ws_clear = 0, n_load_rise = 0, n_load_cyc = 0, n_busy = 0;
  int done_cnt = 0, hs_cnt = 0, vrun = 0;
  bit load_prev = 1'b0, valid_prev = 1'b0, err_prev = 1'b0;
  int f_prev = 0, c_prev = 0;

  // responder state
  int load_cyc = 0, issue_cyc = 0, comp_cyc = 0;
  bit v_prev = 1'b0, hs_end = 1'b0;

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic void push_ev(int kind, int f, int c);
    ev_t e;
    e.kind = kind;
    e.f    = f;
    e.c    = c;
    sb_q.push_back(e);
  endfunction

  function automatic void sb_event(int kind, int f, int c);
    ev_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_unexpected: got event %0d (%0d,%0d), expected no event", kind, f, c);
    end else begin
      e = sb_q.pop_front();
      chk("sb_kind", kind, e.kind);
      if (kind == EV_TILE && e.kind == EV_TILE) begin
        chk("sb_filter_idx", f, e.f);
        chk("sb_channel_idx", c, e.c);
      end
    end
  endfunction

  // Weight store / compute array model driving the DUT inputs one step after each edge.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      hs_end    = v_prev && COMPUTE_READY;
      v_prev    = COMPUTE_VALID;
      load_cyc  = LOAD_WS ? load_cyc + 1 : 0;
      issue_cyc = COMPUTE_VALID ? issue_cyc + 1 : 0;
      if (RESET) comp_cyc = 0;
      else if (hs_end) comp_cyc = 1;
      else if (comp_cyc != 0) comp_cyc++;
      WS_FULL       = (full_delay != 0) && (load_cyc >= full_delay);
      COMPUTE_READY = COMPUTE_VALID && (issue_cyc > ready_delay);
      COMPUTE_DONE  = (comp_cyc != 0 && comp_cyc == done_delay) || (spur_done && issue_cyc == 3);
      if (comp_cyc == done_delay) comp_cyc = 0;
    end
  end

  // Monitor: pops the scoreboard on every handshake, DONE pulse and ERROR rise.
  always @(negedge CLK) begin
    if (RESET) begin
      load_prev  = 1'b0;
      valid_prev = 1'b0;
      err_prev   = 1'b0;
      vrun       = 0;
    end else begin
      if (CLEAR_FIFO) n_clear_fifo++;
      if (WS_CLEAR) n_ws_clear++;
      if (LOAD_WS) n_load_cyc++;
      if (LOAD_WS && !load_prev) n_load_rise++;
      if (BUSY) n_busy++;
      if (COMPUTE_VALID) begin
        vrun++;
        if (valid_prev) begin
          chk("valid_stable_filter", int'(FILTER_IDX), f_prev);
          chk("valid_stable_channel", int'(CHANNEL_IDX), c_prev);
        end
      end else if (valid_prev) begin
        if (exp_vrun != 0) chk("valid_run_len", vrun, exp_vrun);
        vrun = 0;
      end
      if (COMPUTE_VALID && COMPUTE_READY) begin
        sb_event(EV_TILE, int'(FILTER_IDX), int'(CHANNEL_IDX));
        hs_cnt++;
      end
      if (DONE) begin
        sb_event(EV_DONE, 0, 0);
        done_cnt++;
      end
      if (ERROR && !err_prev) sb_event(EV_ERR, 0, 0);
      load_prev  = LOAD_WS;
      valid_prev = COMPUTE_VALID;
      err_prev   = ERROR;
      f_prev     = int'(FILTER_IDX);
      c_prev     = int'(CHANNEL_IDX);
    end
  end

  task automatic clr_stats();
    n_clear_fifo = 0; n_ws_clear = 0; n_load_rise = 0; n_load_cyc = 0;
    n_busy = 0; done_cnt = 0; hs_cnt = 0;
  endtask

  task automatic cfg(input int nf, input int nc, input int tmo);
    CFG_NUM_FILTERS  = 8'(nf);
    CFG_NUM_CHANNELS = 8'(nc);
    CFG_TIMEOUT      = 16'(tmo);
  endtask

  task automatic pulse_start();
    @(posedge CLK); #1 START = 1'b1;
    @(posedge CLK); #1 START = 1'b0;
  endtask

  task automatic wait_done(input int target, input int limit);
    int i = 0;
    while (done_cnt < target && i < limit) begin
      @(posedge CLK);
      i++;
    end
    chk("wait_done", done_cnt, target);
  endtask

  task automatic wait_hs(input int target, input int limit);
    int i = 0;
    while (hs_cnt < target && i < limit) begin
      @(posedge CLK);
      i++;
    end
    chk("wait_handshake", hs_cnt, target);
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_busy"}, int'(BUSY), 0);
    chk({tag, "_done"}, int'(DONE), 0);
    chk({tag, "_error"}, int'(ERROR), 0);
    chk({tag, "_clear_fifo"}, int'(CLEAR_FIFO), 0);
    chk({tag, "_ws_clear"}, int'(WS_CLEAR), 0);
    chk({tag, "_load_ws"}, int'(LOAD_WS), 0);
    chk({tag, "_compute_valid"}, int'(COMPUTE_VALID), 0);
    chk({tag, "_filter_idx"}, int'(FILTER_IDX), 0);
    chk({tag, "_channel_idx"}, int'(CHANNEL_IDX), 0);
  endtask

  initial begin
    #1 RESET = 1'b1;
    #2 chk_all_zero("reset");
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;

    // Job 1: 2x3 tiles, start-to-load timing and full tile order.
    cfg(2, 3, 0);
    full_delay = 5; ready_delay = 0; done_delay = 4;
    clr_stats();
    for (int f = 0; f < 2; f++)
      for (int c = 0; c < 3; c++) push_ev(EV_TILE, f, c);
    push_ev(EV_DONE, 0, 0);
    pulse_start();
    @(negedge CLK);
    chk("k1_busy", int'(BUSY), 1);
    chk("k1_clear_fifo", int'(CLEAR_FIFO), 1);
    @(negedge CLK);
    chk("k2_ws_clear", int'(WS_CLEAR), 1);
    chk("k2_load_ws", int'(LOAD_WS), 0);
    @(negedge CLK);
    chk("k3_load_ws", int'(LOAD_WS), 1);
    wait_done(1, 2000);
    @(negedge CLK);
    chk("j1_busy_after_done", int'(BUSY), 0);
    @(posedge CLK);
    chk("j1_load_rises", n_load_rise, 6);
    chk("j1_clear_fifo", n_clear_fifo, 1);
    chk("j1_ws_clear", n_ws_clear, 6);
    chk("j1_error", int'(ERROR), 0);
    chk("j1_hold_filter", int'(FILTER_IDX), 1);
    chk("j1_hold_channel", int'(CHANNEL_IDX), 2);

    // Job 2: load timeout of 10 cycles with the store never filling.
    cfg(1, 1, 10);
    full_delay = 0;
    clr_stats();
    push_ev(EV_ERR, 0, 0);
    pulse_start();
    for (int i = 0; i < 200 && !ERROR; i++) @(posedge CLK);
    chk("j2_error", int'(ERROR), 1);
    repeat (3) @(posedge CLK);
    chk("j2_error_sticky", int'(ERROR), 1);
    chk("j2_load_cycles", n_load_cyc, 10);
    chk("j2_no_done", done_cnt, 0);
    chk("j2_busy", int'(BUSY), 0);

    // Job 3: zero filter count finishes immediately and clears ERROR.
    cfg(0, 3, 0);
    full_delay = 5;
    clr_stats();
    push_ev(EV_DONE, 0, 0);
    pulse_start();
    @(negedge CLK);
    chk("j3_done_k1", int'(DONE), 1);
    chk("j3_busy_k1", int'(BUSY), 1);
    chk("j3_error_cleared", int'(ERROR), 0);
    @(negedge CLK);
    chk("j3_busy_k2", int'(BUSY), 0);
    @(posedge CLK);
    chk("j3_busy_cycles", n_busy, 1);
    chk("j3_clear_fifo", n_clear_fifo, 0);
    chk("j3_ws_clear", n_ws_clear, 0);
    chk("j3_load_rises", n_load_rise, 0);

    // Job 4: READY held low 7 cycles, spurious COMPUTE_DONE during ISSUE.
    cfg(1, 2, 0);
    ready_delay = 7; spur_done = 1'b1; exp_vrun = 8;
    clr_stats();
    push_ev(EV_TILE, 0, 0);
    push_ev(EV_TILE, 0, 1);
    push_ev(EV_DONE, 0, 0);
    pulse_start();
    wait_done(1, 2000);
    @(posedge CLK);
    chk("j4_load_rises", n_load_rise, 2);
    ready_delay = 0; spur_done = 1'b0; exp_vrun = 0;

    // Job 5: asynchronous reset during LOAD of tile (0,1), then restart.
    cfg(1, 3, 0);
    clr_stats();
    push_ev(EV_TILE, 0, 0);
    pulse_start();
    for (int i = 0; i < 300 && !(LOAD_WS && CHANNEL_IDX == 8'd1); i++) @(negedge CLK);
    chk("j5_reach_load_01", int'(LOAD_WS && CHANNEL_IDX == 8'd1), 1);
    #1 RESET = 1'b1;
    #1 chk_all_zero("async_reset");
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    chk("j5_sb_drained", sb_q.size(), 0);
    cfg(1, 1, 0);
    clr_stats();
    push_ev(EV_TILE, 0, 0);
    push_ev(EV_DONE, 0, 0);
    pulse_start();
    @(negedge CLK);
    chk("j5_restart_clear_fifo", int'(CLEAR_FIFO), 1);
    chk("j5_restart_filter", int'(FILTER_IDX), 0);
    chk("j5_restart_channel", int'(CHANNEL_IDX), 0);
    wait_done(1, 2000);

    // Job 6: START during COMPUTE ignored; START held through FINISH relaunches.
    cfg(1, 2, 0);
    done_delay = 6;
    clr_stats();
    for (int j = 0; j < 2; j++) begin
      push_ev(EV_TILE, 0, 0);
      push_ev(EV_TILE, 0, 1);
      push_ev(EV_DONE, 0, 0);
    end
    pulse_start();
    wait_hs(1, 500);
    #1 START = 1'b1;
    @(posedge CLK); #1 START = 1'b0;
    wait_hs(2, 500);
    #1 START = 1'b1;
    wait_done(1, 2000);
    @(negedge CLK);
    chk("j6_idle_after_done", int'(BUSY), 0);
    @(negedge CLK);
    chk("j6_relaunch_clear_fifo", int'(CLEAR_FIFO), 1);
    @(posedge CLK); #1 START = 1'b0;
    wait_done(2, 2000);
    @(posedge CLK);
    chk("j6_clear_fifo", n_clear_fifo, 2);
    chk("j6_load_rises", n_load_rise, 4);

    chk("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
